data_slave: RTL and testbench

Receiving end of the valid/ready data interface driven by the `data_master` family. It accepts beats from an upstream master into a small first-word-fall-through FIFO and presents them to a downstream consumer through its own valid/ready handshake. The upstream master holds `valid` for only one cycle, so a beat offered while this block is not ready is lost. The block therefore counts such lost beats for debug and bring-up.

---
 rtl/data_slave_if.sv | 27 ++
 rtl/data_slave.sv | 73 +++++++
 tb/tb_data_slave.sv | 135 +++++++++++++
 3 files changed

// File: rtl/data_slave_if.sv
// Valid/ready bundle between an upstream data_master, this FIFO slave and its
// downstream consumer, plus the occupancy and drop-count debug outputs.
interface data_slave_if #(
   parameter int unsigned width = 4,
   parameter int unsigned depth = 4
);
   localparam int unsigned aw = $clog2(depth);

   logic             valid;
   logic [width-1:0] data;
   logic             ready;
   logic [width-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [aw:0]      level;
   logic [7:0]       drop_cnt;

   modport master (
      output valid, data, out_ready,
      input  ready, out_data, out_valid, level, drop_cnt
   );

   modport slave (
      input  valid, data, out_ready,
      output ready, out_data, out_valid, level, drop_cnt
   );
endinterface

// File: rtl/data_slave.sv
// First-word-fall-through FIFO receiving single-cycle valid beats; beats offered
// while full are lost and counted in a saturating debug counter.
module data_slave #(
   parameter int unsigned width = 4,
   parameter int unsigned depth = 4
) (
   input logic         clk,
   input logic         rst,
   data_slave_if.slave bus
);
   localparam int unsigned aw = $clog2(depth);
   localparam logic [aw:0] full_lvl = depth[aw:0];

   logic [width-1:0] mem_q [depth];
   logic [width-1:0] mem_d [depth];
   logic [aw-1:0]    wr_ptr_q, wr_ptr_d;
   logic [aw-1:0]    rd_ptr_q, rd_ptr_d;
   logic [aw:0]      count_q, count_d;
   logic [7:0]       drop_q, drop_d;
   logic             push, pop;

   // ready is held low through reset so nothing is accepted on the reset edge
   assign bus.ready     = !rst && (count_q != full_lvl);
   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = mem_q[rd_ptr_q];
   assign bus.level     = count_q;
   assign bus.drop_cnt  = drop_q;

   assign push = bus.valid && bus.ready;
   assign pop  = bus.out_valid && bus.out_ready;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;

      if (push) begin
         mem_d[wr_ptr_q] = bus.data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (bus.valid && !bus.ready && (drop_q != 8'hff)) begin
         drop_d = drop_q + 1'b1;
      end
   end

   // Storage is not reset; only the pointers and counters are.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end
endmodule

// File: tb/tb_data_slave.sv
// Scoreboard bench for data_slave: a queue model of the FIFO plus a drop counter,
// directed scenarios followed by randomized traffic with occasional resets.
module tb_data_slave;
   localparam int unsigned W = 4;
   localparam int unsigned D = 4;

   logic clk;
   logic rst;

   data_slave_if #(.width(W), .depth(D)) bus ();

   data_slave #(.width(W), .depth(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [W-1:0] sb_q [$];
   int           md     = 0;
   bit           acc_ok = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update on the clock edge: accept if there was room, else count a drop.
   always @(posedge clk) begin
      if (rst) begin
         sb_q.delete();
         md = 0;
      end else if (bus.valid) begin
         if (acc_ok) sb_q.push_back(bus.data);
         else if (md < 255) md = md + 1;
      end
   end

   // Monitor mid-cycle: compare handshake/status outputs and pop delivered beats.
   always @(negedge clk) begin
      acc_ok = !rst && (sb_q.size() < D);
      chk("ready", 32'(bus.ready), 32'(acc_ok));
      chk("out_valid", 32'(bus.out_valid), 32'(sb_q.size() != 0));
      chk("level", 32'(bus.level), 32'(sb_q.size()));
      chk("drop_cnt", 32'(bus.drop_cnt), 32'(md));
      if (!rst && sb_q.size() != 0 && bus.out_ready) begin
         chk("out_data", 32'(bus.out_data), 32'(sb_q[0]));
         void'(sb_q.pop_front());
      end
   end

   task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input logic o);
      rst           = r;
      bus.valid     = v;
      bus.data      = d;
      bus.out_ready = o;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst           = 1'b1;
      bus.valid     = 1'b0;
      bus.data      = '0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 4'h0, 1'b0);

      // Single beat in, then one pop.
      drive(1'b0, 1'b1, 4'hA, 1'b0);
      chk("single_level", 32'(bus.level), 32'd1);
      chk("single_data", 32'(bus.out_data), 32'hA);
      drive(1'b0, 1'b0, 4'h0, 1'b0);
      drive(1'b0, 1'b0, 4'h0, 1'b1);
      chk("single_empty", 32'(bus.out_valid), 32'd0);

      // Fill, offer one more, drain in order.
      for (int i = 1; i <= 4; i++) drive(1'b0, 1'b1, 4'(i), 1'b0);
      drive(1'b0, 1'b1, 4'h5, 1'b0);
      chk("full_level", 32'(bus.level), 32'd4);
      chk("full_drop", 32'(bus.drop_cnt), 32'd1);
      repeat (5) drive(1'b0, 1'b0, 4'h0, 1'b1);

      // Full with a same-cycle pop: beat still dropped.
      for (int i = 1; i <= 4; i++) drive(1'b0, 1'b1, 4'(i + 8), 1'b0);
      drive(1'b0, 1'b1, 4'h9, 1'b1);
      chk("fullpop_level", 32'(bus.level), 32'd3);
      chk("fullpop_ready", 32'(bus.ready), 32'd1);
      chk("fullpop_drop", 32'(bus.drop_cnt), 32'd2);
      repeat (4) drive(1'b0, 1'b0, 4'h0, 1'b1);

      // Streaming with pointer wrap.
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 4'(i), 1'b1);
      drive(1'b0, 1'b0, 4'h0, 1'b1);
      chk("stream_drop", 32'(bus.drop_cnt), 32'd2);

      // Drop saturation.
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 4'(i), 1'b0);
      repeat (300) drive(1'b0, 1'b1, 4'($urandom), 1'b0);
      chk("sat_drop", 32'(bus.drop_cnt), 32'd255);

      // Reset with push and pop on the reset edge.
      drive(1'b0, 1'b0, 4'h0, 1'b1);
      chk("pre_rst_level", 32'(bus.level), 32'd3);
      drive(1'b1, 1'b1, 4'h7, 1'b1);
      chk("rst_level", 32'(bus.level), 32'd0);
      chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
      drive(1'b0, 1'b1, 4'h6, 1'b0);
      chk("after_rst_data", 32'(bus.out_data), 32'h6);
      drive(1'b0, 1'b0, 4'h0, 1'b1);

      // Random traffic with varying back-pressure and rare resets.
      for (int i = 0; i < 3000; i++) begin
         logic r, v, o;
         r = ($urandom_range(0, 249) == 0);
         v = ($urandom_range(0, 3) != 0);
         o = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
         drive(r, v, 4'($urandom), o);
      end
      repeat (6) drive(1'b0, 1'b0, 4'h0, 1'b1);
      chk("final_empty", 32'(bus.out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
